// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO controller / pointer unit interface.
package fifo_pkg;

   // Widths of the controller <-> pointer unit vectors
   localparam int unsigned CTL_WIDTH = 5;
   localparam int unsigned ST_WIDTH  = 4;

   // control_signals bit positions
   localparam int unsigned CTL_W_TRIG = 0;
   localparam int unsigned CTL_R_TRIG = 1;
   localparam int unsigned CTL_CLR    = 2;
   localparam int unsigned CTL_READ   = 3;
   localparam int unsigned CTL_LOAD   = 4;

   // status_signals bit positions
   localparam int unsigned ST_EMPTY      = 0;
   localparam int unsigned ST_EMPTY_FWFT = 1;
   localparam int unsigned ST_EQ_FULL    = 2;
   localparam int unsigned ST_NEQ        = 3;

   // status_signals while pointers sit at zero (empty, both empty views set)
   localparam logic [ST_WIDTH-1:0] STATUS_RST = 4'b0111;

   // Decoded view of control_signals
   typedef struct packed {
      logic load_data;
      logic read_data;
      logic clr;
      logic r_trig;
      logic w_trig;
   } ctl_t;

   function automatic ctl_t decode_ctl(input logic [CTL_WIDTH-1:0] ctl);
      ctl_t c;
      c.load_data = ctl[CTL_LOAD];
      c.read_data = ctl[CTL_READ];
      c.clr       = ctl[CTL_CLR];
      c.r_trig    = ctl[CTL_R_TRIG];
      c.w_trig    = ctl[CTL_W_TRIG];
      return c;
   endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// Wrapping pointer counter with synchronous clear (clear wins over increment).
module fifo_ptr_counter #(
   parameter int unsigned Width = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] cnt_d, cnt_q;

   // Next count: clear, else increment modulo 2**Width
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_pointer_unit.sv
// FIFO pointer unit: write/read pointers, RAM addressing, status flags,
// occupancy and sticky error flags.
module fifo_pointer_unit
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned AF_MARGIN  = 2,
   parameter int unsigned AE_MARGIN  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CTL_WIDTH-1:0]  control_signals,
   output logic [ST_WIDTH-1:0]   status_signals,
   output logic [ADDR_WIDTH-1:0] wr_adr,
   output logic [ADDR_WIDTH-1:0] rd_adr,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   localparam int unsigned PtrW  = ADDR_WIDTH + 1;
   localparam int unsigned Depth = 1 << ADDR_WIDTH;
   localparam logic [PtrW-1:0] AfLevel = PtrW'(Depth - AF_MARGIN);
   localparam logic [PtrW-1:0] AeLevel = PtrW'(AE_MARGIN);

   ctl_t ctl;
   assign ctl = decode_ctl(control_signals);

   logic [PtrW-1:0] wr_ptr, rd_ptr;
   logic [PtrW-1:0] wr_ptr_d1_d, wr_ptr_d1_q;
   logic            ovf_d, ovf_q;
   logic            unf_d, unf_q;
   logic            neq, eq_full, eq_empty, eq_empty_fwft, full;

   fifo_ptr_counter #(
      .Width (PtrW)
   ) u_wr_ptr (
      .clk_i  (clk),
      .rst_ni (rst),
      .inc_i  (ctl.w_trig),
      .clr_i  (ctl.clr),
      .cnt_o  (wr_ptr)
   );

   fifo_ptr_counter #(
      .Width (PtrW)
   ) u_rd_ptr (
      .clk_i  (clk),
      .rst_ni (rst),
      .inc_i  (ctl.r_trig),
      .clr_i  (ctl.clr),
      .cnt_o  (rd_ptr)
   );

   // Pointer comparison flags from registered state
   always_comb begin
      neq           = wr_ptr[PtrW-1] != rd_ptr[PtrW-1];
      eq_full       = wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0];
      eq_empty      = wr_ptr == rd_ptr;
      eq_empty_fwft = wr_ptr_d1_q == rd_ptr;
      full          = neq & eq_full;
   end

   // Next state for delayed write pointer and sticky errors; the block flags
   // misuse but never blocks a pointer from moving.
   always_comb begin
      wr_ptr_d1_d = wr_ptr;
      ovf_d       = ovf_q | (ctl.w_trig & full);
      unf_d       = unf_q | (ctl.r_trig & eq_empty);
      if (ctl.clr) begin
         wr_ptr_d1_d = '0;
         ovf_d       = 1'b0;
         unf_d       = 1'b0;
      end
   end

   // Delayed write pointer and error flag registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_d1_q <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         wr_ptr_d1_q <= wr_ptr_d1_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   // Output assembly
   always_comb begin
      status_signals                = '0;
      status_signals[ST_NEQ]        = neq;
      status_signals[ST_EQ_FULL]    = eq_full;
      status_signals[ST_EMPTY_FWFT] = eq_empty_fwft;
      status_signals[ST_EMPTY]      = eq_empty;
      // Modulo difference: misuse past full shows up as a wrapped value
      level         = wr_ptr - rd_ptr;
      almost_full   = level >= AfLevel;
      almost_empty  = level <= AeLevel;
      wr_adr        = wr_ptr[ADDR_WIDTH-1:0];
      rd_adr        = rd_ptr[ADDR_WIDTH-1:0];
      mem_we        = ctl.load_data;
      mem_re        = ctl.read_data;
      overflow_err  = ovf_q;
      underflow_err = unf_q;
   end

endmodule

// File: tb/tb_fifo_pointer_unit.sv
// Randomised and directed bench for fifo_pointer_unit (ADDR_WIDTH=2).
module tb_fifo_pointer_unit;

   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int MODV  = 8;

   logic          clk;
   logic          rst;
   logic [4:0]    control;
   logic [3:0]    status_signals;
   logic [AW-1:0] wr_adr, rd_adr;
   logic          mem_we, mem_re;
   logic [AW:0]   level;
   logic          almost_full, almost_empty, overflow_err, underflow_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: occupancy bookkeeping with plain integers
   int m_wr, m_rd, m_wrd1;
   bit m_ovf, m_unf;

   fifo_pointer_unit #(
      .ADDR_WIDTH (AW),
      .AF_MARGIN  (1),
      .AE_MARGIN  (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .control_signals (control),
      .status_signals  (status_signals),
      .wr_adr          (wr_adr),
      .rd_adr          (rd_adr),
      .mem_we          (mem_we),
      .mem_re          (mem_re),
      .level           (level),
      .almost_full     (almost_full),
      .almost_empty    (almost_empty),
      .overflow_err    (overflow_err),
      .underflow_err   (underflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wr = 0; m_rd = 0; m_wrd1 = 0; m_ovf = 0; m_unf = 0;
   endtask

   // One rising edge worth of model behaviour
   task automatic model_edge(input logic [4:0] ctl);
      int occ;
      occ = (m_wr - m_rd + MODV) % MODV;
      if (ctl[2]) begin
         model_reset();
      end else begin
         if (ctl[0] && occ == DEPTH) m_ovf = 1;
         if (ctl[1] && occ == 0) m_unf = 1;
         m_wrd1 = m_wr;
         m_wr   = (m_wr + int'(ctl[0])) % MODV;
         m_rd   = (m_rd + int'(ctl[1])) % MODV;
      end
   endtask

   task automatic check_all(input string ph);
      int lvl;
      logic [3:0] st;
      lvl   = (m_wr - m_rd + MODV) % MODV;
      st[3] = (m_wr / DEPTH) != (m_rd / DEPTH);
      st[2] = (m_wr % DEPTH) == (m_rd % DEPTH);
      st[1] = m_wrd1 == m_rd;
      st[0] = m_wr == m_rd;
      check({ph, ".wr_adr"}, 32'(wr_adr), 32'(m_wr % DEPTH));
      check({ph, ".rd_adr"}, 32'(rd_adr), 32'(m_rd % DEPTH));
      check({ph, ".status"}, 32'(status_signals), 32'(st));
      check({ph, ".full"}, 32'(status_signals[3] & status_signals[2]), 32'(lvl == DEPTH));
      check({ph, ".level"}, 32'(level), 32'(lvl));
      check({ph, ".afull"}, 32'(almost_full), 32'(lvl >= DEPTH - 1));
      check({ph, ".aempty"}, 32'(almost_empty), 32'(lvl <= 1));
      check({ph, ".ovf"}, 32'(overflow_err), 32'(m_ovf));
      check({ph, ".unf"}, 32'(underflow_err), 32'(m_unf));
   endtask

   task automatic step(input string ph, input logic [4:0] ctl);
      @(negedge clk);
      control = ctl;
      #1;
      check({ph, ".mem_we"}, 32'(mem_we), 32'(ctl[4]));
      check({ph, ".mem_re"}, 32'(mem_re), 32'(ctl[1 + 2]));
      model_edge(ctl);
      @(posedge clk);
      #1;
      check_all(ph);
   endtask

   // Asynchronous reset pulse landing between clock edges
   task automatic async_reset(input string ph);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check_all(ph);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [4:0] ctl;
      rst     = 1'b0;
      control = 5'b00000;
      model_reset();
      #12;
      check_all("reset");
      check("reset.status_lit", 32'(status_signals), 32'h7);
      @(negedge clk);
      rst = 1'b1;

      // Fill from empty: addresses 1,2,3,0 and status 1100 at the end
      for (int i = 0; i < 4; i++) step("fill", 5'b10001);
      check("fill.status_lit", 32'(status_signals), 32'hc);

      // Single write into empty: fwft view lags the plain empty view
      step("clr1", 5'b00100);
      step("w1", 5'b10001);
      check("w1.fwft_still", 32'(status_signals[1]), 32'h1);
      step("w1.idle", 5'b00000);
      check("w1.fwft_low", 32'(status_signals[1]), 32'h0);

      // Simultaneous read+write below full keeps level steady
      step("clr2", 5'b00100);
      for (int i = 0; i < 3; i++) step("fill3", 5'b10001);
      for (int i = 0; i < 5; i++) step("rw", 5'b11011);

      // Underflow is sticky until clr
      step("clr3", 5'b00100);
      step("unf", 5'b01010);
      step("unf.hold", 5'b00000);
      step("unf.clr", 5'b00100);

      // Overflow at full, then check it sticks
      for (int i = 0; i < 4; i++) step("fill4", 5'b10001);
      step("ovf", 5'b10001);
      step("ovf.hold", 5'b01010);
      step("ovf.hold2", 5'b00000);

      // Async reset mid-run with pointers at 3 and 1
      step("clr4", 5'b00100);
      for (int i = 0; i < 3; i++) step("pre", 5'b10001);
      step("pre.rd", 5'b01010);
      control = 5'b00000;
      async_reset("arst");

      // Random traffic; clr kept rare so the FIFO reaches full and wraps
      for (int i = 0; i < 600; i++) begin
         ctl = 5'($urandom);
         if ($urandom_range(15) != 0) ctl[2] = 1'b0;
         if ($urandom_range(99) == 0) begin
            control = 5'b00000;
            async_reset("rnd.arst");
         end else begin
            step("rnd", ctl);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
